// File: rtl/muldiv_pkg.sv
// Shared types for the multiply/divide sequencer: ALU op encodings, request ops, FSM states.
package muldiv_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;

  typedef enum logic [1:0] {
    MULTU = 2'b00,
    MULT  = 2'b01,
    DIVU  = 2'b10,
    DIV   = 2'b11
  } md_op_t;

  typedef enum logic [2:0] {
    IDLE,
    NEG_A,
    NEG_B,
    ITER,
    FIX_LO,
    FIX_HI,
    DONE
  } md_state_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/result and shared-ALU signals between the execute stage and the muldiv sequencer.
interface muldiv_sequencer_if;
  import muldiv_pkg::*;

  logic        start;
  md_op_t      op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;

  modport master (
    output start, op, rs, rt, alu_result,
    input  busy, done, hi, lo, alu_op, alu_a, alu_b
  );

  modport slave (
    input  start, op, rs, rt, alu_result,
    output busy, done, hi, lo, alu_op, alu_a, alu_b
  );

endinterface

// File: rtl/muldiv_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer: shift-add multiply, restoring divide, all arithmetic on the shared ALU.
// Latency: done 33 cycles after start (unsigned), 37 (signed), 1 (divide by zero).
// No backpressure: start is only accepted in IDLE; busy stalls the pipeline otherwise.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter logic [31:0] DIV0_LO = 32'hFFFFFFFF
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_sequencer_if.slave bus
);

  md_state_t   state;
  logic [31:0] hi_r, lo_r, breg;
  logic        sa, sb, is_div, is_sgn;
  logic [4:0]  cnt;
  logic        busy_r, done_r;

  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic [31:0] hs;
  logic        m;
  logic        req_div, req_sgn;

  assign hs      = {hi_r[30:0], lo_r[31]};
  assign m       = hi_r[31];
  assign req_div = (bus.op == DIVU) || (bus.op == DIV);
  assign req_sgn = (bus.op == MULT) || (bus.op == DIV);

  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = 32'd0;
    alu_b  = 32'd0;
    case (state)
      NEG_A:  begin alu_op = ALU_SUB; alu_b = lo_r; end
      NEG_B:  begin alu_op = ALU_SUB; alu_b = breg; end
      ITER: begin
        alu_op = is_div ? ALU_SUB : ALU_ADD;
        alu_a  = is_div ? hs : hi_r;
        alu_b  = breg;
      end
      FIX_LO: begin alu_op = ALU_SUB; alu_b = lo_r; end
      FIX_HI: begin
        if (is_div) begin
          alu_op = ALU_SUB;
          alu_b  = hi_r;
        end else begin
          // Upper half of a 64-bit negate: invert, carry in from a zero low half.
          alu_a = ~hi_r;
          alu_b = {31'd0, lo_r == 32'd0};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      hi_r   <= 32'd0;
      lo_r   <= 32'd0;
      breg   <= 32'd0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      is_div <= 1'b0;
      is_sgn <= 1'b0;
      cnt    <= 5'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          hi_r   <= 32'd0;
          lo_r   <= bus.rs;
          breg   <= bus.rt;
          sa     <= req_sgn & bus.rs[31];
          sb     <= req_sgn & bus.rt[31];
          is_div <= req_div;
          is_sgn <= req_sgn;
          cnt    <= 5'd0;
          busy_r <= 1'b1;
          if (req_div && bus.rt == 32'd0) begin
            hi_r   <= bus.rs;
            lo_r   <= DIV0_LO;
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            state <= req_sgn ? NEG_A : ITER;
          end
        end
        NEG_A: begin
          if (sa) lo_r <= bus.alu_result;
          state <= NEG_B;
        end
        NEG_B: begin
          if (sb) breg <= bus.alu_result;
          state <= ITER;
        end
        ITER: begin
          if (is_div) begin
            if (m || !(hs < breg)) begin
              hi_r <= bus.alu_result;
              lo_r <= {lo_r[30:0], 1'b1};
            end else begin
              hi_r <= hs;
              lo_r <= {lo_r[30:0], 1'b0};
            end
          end else if (lo_r[0]) begin
            // Carry out of hi+breg becomes the new top bit of the 65-bit shift.
            hi_r <= {bus.alu_result < hi_r, bus.alu_result[31:1]};
            lo_r <= {bus.alu_result[0], lo_r[31:1]};
          end else begin
            hi_r <= {1'b0, hi_r[31:1]};
            lo_r <= {hi_r[0], lo_r[31:1]};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            if (is_sgn) begin
              state <= FIX_LO;
            end else begin
              done_r <= 1'b1;
              state  <= DONE;
            end
          end
        end
        FIX_LO: begin
          if (sa ^ sb) lo_r <= bus.alu_result;
          state <= FIX_HI;
        end
        FIX_HI: begin
          if (is_div ? sa : (sa ^ sb)) hi_r <= bus.alu_result;
          done_r <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.hi     = hi_r;
  assign bus.lo     = lo_r;
  assign bus.alu_op = alu_op;
  assign bus.alu_a  = alu_a;
  assign bus.alu_b  = alu_b;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + random bench for muldiv_sequencer with a behavioural ALU and a reference-model scoreboard.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_sequencer_if bus();

  muldiv_sequencer #(.DIV0_LO(32'hFFFFFFFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always_comb begin
    case (bus.alu_op)
      ALU_AND: bus.alu_result = bus.alu_a & bus.alu_b;
      ALU_OR:  bus.alu_result = bus.alu_a | bus.alu_b;
      ALU_ADD: bus.alu_result = bus.alu_a + bus.alu_b;
      ALU_SUB: bus.alu_result = bus.alu_a - bus.alu_b;
      default: bus.alu_result = 32'd0;
    endcase
  end

  int   nvec = 0;
  int   nfail = 0;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input md_op_t o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      x, y, q, r;
    x = longint'($signed(a));
    y = longint'($signed(b));
    p = 64'd0;
    q = 0;
    r = 0;
    case (o)
      MULTU: begin p = {32'd0, a} * {32'd0, b}; e.lat = 33; end
      MULT:  begin p = x * y;                   e.lat = 37; end
      DIVU:  if (b != 32'd0) begin q = longint'({32'd0, a / b}); r = longint'({32'd0, a % b}); e.lat = 33; end
      default: if (b != 32'd0) begin q = x / y; r = x % y; e.lat = 37; end
    endcase
    if (o == MULTU || o == MULT) begin
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.hi  = a;
      e.lo  = 32'hFFFFFFFF;
      e.lat = 1;
    end else begin
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    return e;
  endfunction

  // Issues one operation; optionally pulses start again at glitch_at or resets at rst_at.
  task automatic run(input string tag, input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                     input int glitch_at, input int rst_at);
    exp_t e;
    int   cyc;
    logic busy_ok, seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.rs    = a;
    bus.rt    = b;
    sb_q.push_back(model(o, a, b));
    @(negedge clk);
    cyc     = 1;
    busy_ok = 1'b1;
    while (cyc < 60) begin
      bus.start = (cyc == glitch_at);
      if (cyc == glitch_at) begin
        bus.op = DIVU;
        bus.rs = $urandom;
        bus.rt = $urandom;
      end
      if (bus.done === 1'b1) break;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (cyc == rst_at) break;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    e = sb_q.pop_front();
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    if (rst_at > 0) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check({tag, "_rst_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_rst_done"}, 32'(bus.done), 32'd0);
      check({tag, "_rst_hi"}, bus.hi, 32'd0);
      check({tag, "_rst_lo"}, bus.lo, 32'd0);
      seen = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (bus.done !== 1'b0) seen = 1'b1;
      end
      check({tag, "_no_done"}, 32'(seen), 32'd0);
    end else begin
      check({tag, "_done"}, 32'(bus.done), 32'd1);
      check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
      check({tag, "_hi"}, bus.hi, e.hi);
      check({tag, "_lo"}, bus.lo, e.lo);
      @(negedge clk);
      check({tag, "_pulse"}, 32'(bus.done), 32'd0);
      check({tag, "_idle"}, 32'(bus.busy), 32'd0);
      check({tag, "_hold_hi"}, bus.hi, e.hi);
      check({tag, "_hold_lo"}, bus.lo, e.lo);
    end
  endtask

  initial begin
    md_op_t      ro;
    logic [31:0] ra, rb;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = MULTU;
    bus.rs    = 32'd0;
    bus.rt    = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'(ALU_ADD));
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_b", bus.alu_b, 32'd0);

    run("multu_max",  MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    check("multu_max_hi_const", bus.hi, 32'hFFFFFFFE);
    check("multu_max_lo_const", bus.lo, 32'h00000001);
    run("mult_neg",   MULT,  32'hFFFFFFFD, 32'd7, 0, 0);
    check("mult_neg_lo_const", bus.lo, 32'hFFFFFFEB);
    run("divu_100_7", DIVU,  32'd100, 32'd7, 0, 0);
    check("divu_lo_const", bus.lo, 32'd14);
    check("divu_hi_const", bus.hi, 32'd2);
    run("div_neg7_2", DIV,   32'hFFFFFFF9, 32'd2, 0, 0);
    run("div_ovf",    DIV,   32'h80000000, 32'hFFFFFFFF, 0, 0);
    check("div_ovf_lo_const", bus.lo, 32'h80000000);
    run("divu_zero",  DIVU,  32'd5, 32'd0, 0, 0);
    run("div_zero",   DIV,   32'hFFFFFF00, 32'd0, 0, 0);
    run("ign_start",  MULTU, 32'd6, 32'd7, 5, 0);
    check("ign_start_lo_const", bus.lo, 32'd42);
    run("mult_pos",   MULT,  32'd12345, 32'd678, 0, 0);
    run("abort",      MULTU, 32'h12345678, 32'h9ABCDEF0, 0, 10);

    for (int i = 0; i < 6; i++) begin
      ro = md_op_t'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      run("rand", ro, ra, rb, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU that time-shares the existing combinational ALU.
- Iterative shift-add multiply and restoring divide. All add/subtract/negate work goes through the ALU's ADD (3'b010) and SUB (3'b011) ops.
- Produces HI/LO for the execute stage's mfhi/mflo path and stalls the pipeline through busy.

Parameters:
- DIV0_LO, 32'hFFFFFFFF, LO value returned on divide-by-zero.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- rs  in  32  multiplicand / dividend.
- rt  in  32  multiplier / divisor.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; hi/lo are final in this cycle.
- hi  out  32  HI register.
- lo  out  32  LO register.
- alu_op  out  3  op driven to the shared ALU.
- alu_a  out  32  ALU operand a.
- alu_b  out  32  ALU operand b.
- alu_result  in  32  ALU result (combinational return).

Behaviour:
- Reset: state IDLE; hi=lo=0; busy=0; done=0; internal counters/flags cleared. Reset mid-operation aborts at the next edge, returns to IDLE, and clears hi/lo.
- IDLE ALU drive: alu_op=ADD, alu_a=alu_b=0.
- States: IDLE, NEG_A, NEG_B, ITER, FIX_LO, FIX_HI, DONE.
- Start in IDLE:
  - Latch hi=0, lo=rs, breg=rt.
  - Latch sign flags sa=rs[31], sb=rt[31], cleared to 0 for unsigned ops.
  - Iteration counter = 0.
- Start in any non-IDLE state is ignored, DONE included.
- Transitions:
  - Divide op with rt==0: IDLE->DONE. Set hi=rs, lo=DIV0_LO, no sign fix.
  - Unsigned: IDLE->ITER.
  - Signed: IDLE->NEG_A.
  - NEG_A->NEG_B->ITER.
  - ITER stays 32 cycles, then goes to DONE (unsigned) or FIX_LO (signed).
  - FIX_LO->FIX_HI->DONE.
  - DONE->IDLE unconditionally.
- Fixed latency. Start seen high in cycle 0 gives done high in:
  - cycle 33 for unsigned ops;
  - cycle 37 for signed ops;
  - cycle 1 for divide-by-zero.
- Signed paths always traverse NEG/FIX states, even for non-negative operands.
- NEG_A: alu SUB a=0, b=lo. If sa, lo=result.
- NEG_B: alu SUB a=0, b=breg. If sb, breg=result.
- Multiply ITER:
  - alu ADD a=hi, b=breg; carry = (alu_result < hi), unsigned compare.
  - If lo[0]: {hi,lo} = {carry, alu_result, lo[31:1]}.
  - Else: {hi,lo} = {1'b0, hi, lo[31:1]}.
- Divide ITER:
  - Form {m, hs} = {hi, lo[31]}, where m = hi[31] and hs = {hi[30:0], lo[31]}.
  - alu SUB a=hs, b=breg.
  - If m | ~(hs < breg): hi=alu_result, lo={lo[30:0],1}.
  - Else: hi=hs, lo={lo[30:0],0}.
- Sign fix:
  - Multiply: neg = sa^sb. FIX_LO: if neg, lo = 0-lo (SUB). FIX_HI: if neg, hi = ~hi + (lo==0) via alu ADD a=~hi, b={31'b0, lo==0}.
  - Divide: FIX_LO negates the quotient (lo) if sa^sb. FIX_HI negates the remainder (hi) via SUB 0-hi if sa.
- Arithmetic wraps mod 2^32. Case: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- hi/lo show intermediate values while busy. They are final when done=1 and hold until the next accepted start or reset.

Decomposition:
- Shared package muldiv_pkg holds:
  - ALU op constants ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b011;
  - the md_op_t enum (MULTU, MULT, DIVU, DIV);
  - the md_state_t enum.
- No sub-module. The ALU stays external and is instantiated beside this block by the parent and by the bench.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> done exactly in cycle 33; hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1-33.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> done in cycle 37; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIVU rs=100, rt=7 -> lo=14, hi=2 in cycle 33. DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF in cycle 37.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU rs=5, rt=0 -> done in cycle 1; hi=5, lo=0xFFFFFFFF.
- Start MULTU 6*7, pulse start with different operands at cycle 5 -> ignored; result hi=0, lo=42 in cycle 33.
- Reset asserted during ITER cycle 10 -> next cycle IDLE, busy=0, hi=lo=0, no done pulse.
